// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - memory-mapped PS/2 host-to-device command transmitter
//
// Purpose: the CPU writes a command byte to TXDATA. The block inhibits the PS/2
// bus, sends a start bit, 8 data bits LSB first, an odd parity bit and a stop
// bit on the device-generated clock, then samples the device ACK. Both PS/2
// lines are open-drain: the block only pulls them low or releases them.
//
// Ports:
//   clock        system clock
//   reset        asynchronous active-low reset
//   address      bus address (TXDATA at BASE_ADDR, STATUS at BASE_ADDR+8)
//   data         bus data; driven only during a STATUS read, otherwise 'bz
//   read         bus read strobe (combinational, same cycle)
//   write        bus write strobe (sampled on posedge clock)
//   ps2_clk_in   PS/2 clock pin (asynchronous)
//   ps2_data_in  PS/2 data pin (asynchronous)
//   ps2_clk_oe   1 = pull PS/2 clock low
//   ps2_data_oe  1 = pull PS/2 data low
//   busy         transfer in progress
//
// STATUS = {59'b0, overrun, timeout, nack, ack_ok, busy}

module ps2_host_tx #(
    parameter logic [63:0] BASE_ADDR      = 64'h0000_0000_0000_F010,
    parameter int          INHIBIT_CYCLES = 5000,
    parameter int          TIMEOUT_CYCLES = 750000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [63:0] address,
    inout  wire  [63:0] data,
    input  logic        read,
    input  logic        write,
    input  logic        ps2_clk_in,
    input  logic        ps2_data_in,
    output logic        ps2_clk_oe,
    output logic        ps2_data_oe,
    output logic        busy
);

    localparam int MAX_CYCLES = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    // INHIBIT ends one cycle before the count would reach INHIBIT_CYCLES, so
    // INHIBIT lasts exactly INHIBIT_CYCLES cycles; START adds one more.
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_INHIBIT   = 3'd1;
    localparam logic [2:0] S_START     = 3'd2;
    localparam logic [2:0] S_SHIFT     = 3'd3;
    localparam logic [2:0] S_ACK       = 3'd4;
    localparam logic [2:0] S_WAIT_IDLE = 3'd5;

    logic [2:0]    state;
    logic [7:0]    tx_byte;
    logic          parity;
    logic [3:0]    bit_idx;
    logic [CW-1:0] cnt;
    logic          ack_ok;
    logic          nack;
    logic          timeout_f;
    logic          overrun;

    logic          clk_meta, sync_clk, sync_clk_prev;
    logic          data_meta, sync_data;
    logic          fall;
    logic          wr_hit, rd_hit;
    logic          cur_bit;
    logic          unused_bus_bits;

    assign busy   = (state != S_IDLE);
    assign fall   = sync_clk_prev & ~sync_clk;
    assign wr_hit = write && (address == BASE_ADDR);
    assign rd_hit = read && (address == BASE_ADDR + 64'd8);

    assign data = rd_hit ? {59'd0, overrun, timeout_f, nack, ack_ok, busy} : {64{1'bz}};

    assign unused_bus_bits = ^data[63:8];

    // Frame bit for the current index: data LSB first, then parity, then stop.
    always_comb begin
        cur_bit = 1'b1;
        if (bit_idx < 4'd8) begin
            cur_bit = tx_byte[bit_idx[2:0]];
        end else if (bit_idx == 4'd8) begin
            cur_bit = parity;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            tx_byte       <= 8'd0;
            parity        <= 1'b0;
            bit_idx       <= 4'd0;
            cnt           <= '0;
            ack_ok        <= 1'b0;
            nack          <= 1'b0;
            timeout_f     <= 1'b0;
            overrun       <= 1'b0;
            ps2_clk_oe    <= 1'b0;
            ps2_data_oe   <= 1'b0;
            clk_meta      <= 1'b0;
            sync_clk      <= 1'b0;
            sync_clk_prev <= 1'b0;
            data_meta     <= 1'b0;
            sync_data     <= 1'b0;
        end else begin
            clk_meta      <= ps2_clk_in;
            sync_clk      <= clk_meta;
            sync_clk_prev <= sync_clk;
            data_meta     <= ps2_data_in;
            sync_data     <= data_meta;

            if (wr_hit && state != S_IDLE) begin
                overrun <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    if (wr_hit) begin
                        tx_byte     <= data[7:0];
                        parity      <= ~^data[7:0];
                        ack_ok      <= 1'b0;
                        nack        <= 1'b0;
                        timeout_f   <= 1'b0;
                        overrun     <= 1'b0;
                        cnt         <= '0;
                        ps2_clk_oe  <= 1'b1;
                        state       <= S_INHIBIT;
                    end
                end

                S_INHIBIT: begin
                    if (cnt == INH_LAST) begin
                        ps2_data_oe <= 1'b1;
                        state       <= S_START;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_START: begin
                    ps2_clk_oe <= 1'b0;
                    bit_idx    <= 4'd0;
                    cnt        <= '0;
                    state      <= S_SHIFT;
                end

                S_SHIFT, S_ACK, S_WAIT_IDLE: begin
                    if (fall) begin
                        cnt <= '0;
                    end else if (cnt == TO_LAST) begin
                        timeout_f   <= 1'b1;
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        state       <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end

                    // A fall clears the timer, so it never coincides with an abort.
                    if (state == S_SHIFT && fall) begin
                        ps2_data_oe <= ~cur_bit;
                        bit_idx     <= bit_idx + 4'd1;
                        if (bit_idx == 4'd9) begin
                            state <= S_ACK;
                        end
                    end

                    if (state == S_ACK && fall) begin
                        ack_ok      <= ~sync_data;
                        nack        <= sync_data;
                        ps2_data_oe <= 1'b0;
                        state       <= S_WAIT_IDLE;
                    end

                    if (state == S_WAIT_IDLE && !(cnt == TO_LAST && !fall)) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        if (sync_clk && sync_data) begin
                            state <= S_IDLE;
                        end
                    end
                end

                default: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - testbench for ps2_host_tx

module tb_ps2_host_tx;

    localparam logic [63:0] BASE = 64'h0000_0000_0000_F010;
    localparam int          INH  = 20;
    localparam int          TO   = 400;
    localparam int          H    = 15;

    logic        clock = 1'b0;
    logic        reset;
    logic [63:0] address;
    logic        read;
    logic        write;
    logic        tb_drv;
    logic [63:0] tb_wdata;
    wire  [63:0] data;
    logic        dev_clk;
    logic        dev_data;
    wire         ps2_clk_oe;
    wire         ps2_data_oe;
    wire         busy;
    wire         ps2_clk_line;
    wire         ps2_data_line;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    assign data          = tb_drv ? tb_wdata : {64{1'bz}};
    assign ps2_clk_line  = ~ps2_clk_oe & dev_clk;
    assign ps2_data_line = ~ps2_data_oe & dev_data;

    ps2_host_tx #(
        .BASE_ADDR      (BASE),
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .address     (address),
        .data        (data),
        .read        (read),
        .write       (write),
        .ps2_clk_in  (ps2_clk_line),
        .ps2_data_in (ps2_data_line),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .busy        (busy)
    );

    typedef struct {
        logic [7:0]  tx;
        bit          ack;
        logic [9:0]  frame;   // {stop, parity, data[7:0]} as seen on the line
        logic [63:0] status;
    } vec_t;

    vec_t        vecs [5];
    logic [9:0]  fr;
    bit          seen;
    bit          ok;
    logic [63:0] st;
    int          width, dwidth, n;
    logic        first_oe, last_d;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int k);
        repeat (k) @(negedge clock);
    endtask

    task automatic bus_write(input logic [7:0] b);
        @(negedge clock);
        address  = BASE;
        tb_wdata = {56'd0, b};
        tb_drv   = 1'b1;
        write    = 1'b1;
        @(posedge clock);
        #1;
        write    = 1'b0;
        tb_drv   = 1'b0;
        address  = 64'd0;
    endtask

    task automatic bus_read(output logic [63:0] v);
        @(negedge clock);
        address = BASE + 64'd8;
        read    = 1'b1;
        #1;
        v       = data;
        read    = 1'b0;
        address = 64'd0;
    endtask

    task automatic wait_idle(input int budget, output bit done);
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
    endtask

    // Device model: waits for the host request-to-send, clocks nbits frame
    // bits (sampling the line on each rising edge), then clocks the ACK.
    task automatic dev_run(input bit ack, input int nbits, output logic [9:0] frame, output bit rts);
        frame = 10'd0;
        rts   = 1'b0;
        for (int i = 0; i < INH + 50; i++) begin
            @(negedge clock);
            if (!ps2_clk_oe && ps2_data_oe) begin
                rts = 1'b1;
                break;
            end
        end
        if (!rts) return;
        cyc(5);
        for (int i = 0; i < 10; i++) begin
            if (i >= nbits) return;
            dev_clk = 1'b0;
            cyc(H);
            dev_clk = 1'b1;
            cyc(H);
            frame[i] = ps2_data_line;
        end
        dev_data = ack ? 1'b0 : 1'b1;
        cyc(H / 2);
        dev_clk = 1'b0;
        cyc(H);
        dev_clk = 1'b1;
        cyc(H);
        dev_data = 1'b1;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{tx: 8'hED, ack: 1'b1, frame: 10'h3ED, status: 64'h2};
        vecs[1] = '{tx: 8'h00, ack: 1'b1, frame: 10'h300, status: 64'h2};
        vecs[2] = '{tx: 8'h01, ack: 1'b0, frame: 10'h201, status: 64'h4};
        vecs[3] = '{tx: 8'hF4, ack: 1'b1, frame: 10'h2F4, status: 64'h2};
        vecs[4] = '{tx: 8'hFF, ack: 1'b1, frame: 10'h3FF, status: 64'h2};

        reset    = 1'b0;
        address  = 64'd0;
        read     = 1'b0;
        write    = 1'b0;
        tb_drv   = 1'b0;
        tb_wdata = 64'd0;
        dev_clk  = 1'b1;
        dev_data = 1'b1;

        cyc(3);
        chk("reset_clk_oe", {63'd0, ps2_clk_oe}, 64'd0);
        chk("reset_data_oe", {63'd0, ps2_data_oe}, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        bus_read(st);
        chk("reset_status", st, 64'h0);
        reset = 1'b1;
        cyc(3);

        // Inhibit window width and start-bit placement, with a full 0xED transfer.
        fork
            dev_run(1'b1, 10, fr, seen);
            begin
                bus_write(8'hED);
                width  = 0;
                dwidth = 0;
                last_d = 1'b0;
                first_oe = 1'b0;
                for (int i = 0; i < INH + 20; i++) begin
                    @(negedge clock);
                    if (i == 0) first_oe = ps2_clk_oe;
                    if (ps2_clk_oe) begin
                        width++;
                        last_d = ps2_data_oe;
                        if (ps2_data_oe) dwidth++;
                    end else if (width > 0) begin
                        break;
                    end
                end
            end
        join
        chk("inhibit_first_cycle", {63'd0, first_oe}, 64'd1);
        chk("inhibit_width", 64'(width), 64'(INH + 1));
        chk("start_bit_width", 64'(dwidth), 64'd1);
        chk("start_bit_before_release", {63'd0, last_d}, 64'd1);
        wait_idle(100, ok);
        chk("t5_idle", {63'd0, ok}, 64'd1);
        chk("t5_frame", {54'd0, fr}, 64'h3ED);
        bus_read(st);
        chk("t5_status", st, 64'h2);

        for (int v = 0; v < 5; v++) begin
            fork
                dev_run(vecs[v].ack, 10, fr, seen);
                bus_write(vecs[v].tx);
            join
            wait_idle(100, ok);
            chk($sformatf("vec%0d_rts", v), {63'd0, seen}, 64'd1);
            chk($sformatf("vec%0d_idle", v), {63'd0, ok}, 64'd1);
            chk($sformatf("vec%0d_frame", v), {54'd0, fr}, {54'd0, vecs[v].frame});
            bus_read(st);
            chk($sformatf("vec%0d_status", v), st, vecs[v].status);
        end

        // Device never clocks: the transfer must abort after the timeout.
        bus_write(8'h55);
        seen = 1'b0;
        for (int i = 0; i < INH + 50; i++) begin
            @(negedge clock);
            if (!ps2_clk_oe && ps2_data_oe) begin
                seen = 1'b1;
                break;
            end
        end
        chk("to_rts", {63'd0, seen}, 64'd1);
        n = 0;
        for (int i = 0; i < TO + 50; i++) begin
            @(negedge clock);
            n++;
            if (!busy) break;
        end
        chk("to_latency_in_range", {63'd0, (n >= TO) && (n <= TO + 2)}, 64'd1);
        chk("to_clk_oe", {63'd0, ps2_clk_oe}, 64'd0);
        chk("to_data_oe", {63'd0, ps2_data_oe}, 64'd0);
        bus_read(st);
        chk("to_status", st, 64'h8);

        // Overrun: second write during SHIFT is ignored.
        bus_write(8'hED);
        fork
            dev_run(1'b1, 10, fr, seen);
            begin
                cyc(INH + 80);
                bus_write(8'hFF);
                bus_read(st);
                chk("ovr_status_busy", st, 64'h11);
            end
        join
        wait_idle(100, ok);
        chk("ovr_idle", {63'd0, ok}, 64'd1);
        chk("ovr_frame", {54'd0, fr}, 64'h3ED);
        bus_read(st);
        chk("ovr_status", st, 64'h12);

        // Reset during bit 4, then a clean 0xF4 transfer.
        bus_write(8'hF4);
        dev_run(1'b1, 5, fr, seen);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_mid_clk_oe", {63'd0, ps2_clk_oe}, 64'd0);
        chk("rst_mid_data_oe", {63'd0, ps2_data_oe}, 64'd0);
        bus_read(st);
        chk("rst_mid_status", st, 64'h0);
        cyc(2);
        reset = 1'b1;
        cyc(3);
        fork
            dev_run(1'b1, 10, fr, seen);
            bus_write(8'hF4);
        join
        wait_idle(100, ok);
        chk("post_rst_frame", {54'd0, fr}, 64'h2F4);
        bus_read(st);
        chk("post_rst_status", st, 64'h2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
